icache_refill_bridge: RTL and testbench

- Sits directly downstream of the icache miss path.
- Accepts line-refill requests (one per MSHR entry) on the icache downstream TXREQ handshake and forwards them as line-aligned reads to the fabric.
- Collects multi-beat fabric read data, assembles each full cache line, and returns it on the icache RXDAT handshake tagged with the originating MSHR entry id.

---
 rtl/icache_refill_bridge_pkg.sv | 28 ++
 rtl/icache_refill_assembler.sv | 87 ++++++++
 rtl/icache_refill_bridge.sv | 136 +++++++++++++
 tb/tb_icache_refill_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_bridge_pkg.sv
// Shared sizing, types and helpers for the icache refill bridge.
// Line-error propagation is enabled by defining ICACHE_REFILL_ERR_EN.
package icache_refill_bridge_pkg;

    localparam int ENTRY_NUM                = 8;
    localparam int ENTRY_ID_WIDTH           = $clog2(ENTRY_NUM);
    localparam int ADDR_WIDTH               = 32;
    localparam int LINE_WIDTH               = 512;
    localparam int BEAT_WIDTH               = 128;
    localparam int ICACHE_REFILL_BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int ICACHE_LINE_OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_CNT_WIDTH           = $clog2(ICACHE_REFILL_BEATS);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(ICACHE_REFILL_BEATS - 1);

    typedef struct packed {
        logic [ENTRY_ID_WIDTH-1:0] tag;
        logic [BEAT_WIDTH-1:0]     data;
        logic                      last;
        logic                      err;
    } refill_beat_t;

    // Fabric reads always fetch whole lines, so the miss byte offset is discarded.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:ICACHE_LINE_OFFSET_WIDTH], {ICACHE_LINE_OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_assembler.sv
// Collects fabric beats into a cache line and holds the finished line on rxdat.
// With ICACHE_REFILL_ERR_EN a sticky per-line error flag is carried to rxdat_err.
module icache_refill_assembler
    import icache_refill_bridge_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      beat_we,
    input  logic [ENTRY_ID_WIDTH-1:0] beat_tag,
    input  logic [BEAT_WIDTH-1:0]     beat_data,
    input  logic                      beat_err,
    output logic [BEAT_CNT_WIDTH-1:0] beat_cnt,
    output logic [ENTRY_ID_WIDTH-1:0] line_tag,
    output logic                      line_done,
    output logic                      beat_rdy,
    output logic                      rxdat_vld,
    input  logic                      rxdat_rdy,
    output logic [LINE_WIDTH-1:0]     rxdat_data,
    output logic [ENTRY_ID_WIDTH-1:0] rxdat_entry_id,
    output logic                      rxdat_err
);

    logic [LINE_WIDTH-1:0] line_buf;
    logic [LINE_WIDTH-1:0] line_next;

    // A beat may only land if a finished line will not be stranded by it.
    assign beat_rdy  = !rxdat_vld | rxdat_rdy;
    assign line_done = beat_we & (beat_cnt == LAST_BEAT);

    always_comb begin
        line_next = line_buf;
        line_next[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line_tag <= '0;
            line_buf <= '0;
        end else if (beat_we) begin
            line_buf <= line_next;
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            if (beat_cnt == '0) begin
                line_tag <= beat_tag;
            end
        end
    end

    // A new line completing in the handshake cycle simply replaces the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxdat_vld      <= 1'b0;
            rxdat_data     <= '0;
            rxdat_entry_id <= '0;
        end else if (line_done) begin
            rxdat_vld      <= 1'b1;
            rxdat_data     <= line_next;
            rxdat_entry_id <= beat_tag;
        end else if (rxdat_rdy) begin
            rxdat_vld <= 1'b0;
        end
    end

`ifdef ICACHE_REFILL_ERR_EN
    logic err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag  <= 1'b0;
            rxdat_err <= 1'b0;
        end else begin
            if (beat_we) begin
                err_flag <= (beat_cnt == LAST_BEAT) ? 1'b0 : (err_flag | beat_err);
            end
            if (line_done) begin
                rxdat_err <= err_flag | beat_err;
            end
        end
    end
`else
    logic err_unused;

    assign err_unused = beat_err;
    assign rxdat_err  = 1'b0;
`endif

endmodule

// File: rtl/icache_refill_bridge.sv
// Forwards icache line-refill misses to the fabric and returns assembled lines by MSHR id.
// Define ICACHE_REFILL_ERR_EN to propagate fabric beat errors onto rxdat_err.
module icache_refill_bridge
    import icache_refill_bridge_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      txreq_vld,
    output logic                      txreq_rdy,
    input  logic [ADDR_WIDTH-1:0]     txreq_addr,
    input  logic [ENTRY_ID_WIDTH-1:0] txreq_entry_id,
    output logic                      fab_req_vld,
    input  logic                      fab_req_rdy,
    output logic [ADDR_WIDTH-1:0]     fab_req_addr,
    output logic [ENTRY_ID_WIDTH-1:0] fab_req_tag,
    input  logic                      fab_rsp_vld,
    output logic                      fab_rsp_rdy,
    input  logic [ENTRY_ID_WIDTH-1:0] fab_rsp_tag,
    input  logic [BEAT_WIDTH-1:0]     fab_rsp_data,
    input  logic                      fab_rsp_last,
    input  logic                      fab_rsp_err,
    output logic                      rxdat_vld,
    input  logic                      rxdat_rdy,
    output logic [LINE_WIDTH-1:0]     rxdat_data,
    output logic [ENTRY_ID_WIDTH-1:0] rxdat_entry_id,
    output logic                      rxdat_err,
    output logic [ENTRY_ID_WIDTH:0]   outstanding_cnt,
    output logic                      protocol_err
);

    refill_beat_t              rsp_beat;
    logic [ENTRY_NUM-1:0]      inflight_q;
    logic [ENTRY_NUM-1:0]      inflight_clr;
    logic [ENTRY_NUM-1:0]      inflight_set;
    logic [ENTRY_NUM-1:0]      inflight_next_clear;
    logic                      req_q_vld;
    logic [ADDR_WIDTH-1:0]     req_q_addr;
    logic [ENTRY_ID_WIDTH-1:0] req_q_tag;
    logic                      req_fire;
    logic                      rsp_fire;
    logic                      beat_we;
    logic                      line_done;
    logic                      tag_idle;
    logic                      tag_switch;
    logic                      last_bad;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
    logic [ENTRY_ID_WIDTH-1:0] line_tag;

    assign rsp_beat = '{tag: fab_rsp_tag, data: fab_rsp_data, last: fab_rsp_last, err: fab_rsp_err};

    // Clear and set are kept in separate processes: the request handshake
    // looks at the clear so an id finishing this cycle can be reused at once.
    always_comb begin
        inflight_clr = '0;
        if (line_done) begin
            inflight_clr[rsp_beat.tag] = 1'b1;
        end
    end

    always_comb begin
        inflight_set = '0;
        if (req_fire) begin
            inflight_set[txreq_entry_id] = 1'b1;
        end
    end

    assign inflight_next_clear = inflight_q & ~inflight_clr;
    assign txreq_rdy = (!req_q_vld | fab_req_rdy) & !inflight_next_clear[txreq_entry_id];
    assign req_fire  = txreq_vld & txreq_rdy;

    assign fab_req_vld  = req_q_vld;
    assign fab_req_addr = req_q_addr;
    assign fab_req_tag  = req_q_tag;

    assign rsp_fire   = fab_rsp_vld & fab_rsp_rdy;
    assign tag_idle   = !inflight_q[rsp_beat.tag];
    assign tag_switch = (beat_cnt != '0) & (rsp_beat.tag != line_tag);
    assign last_bad   = rsp_beat.last != (beat_cnt == LAST_BEAT);
    assign beat_we    = rsp_fire & !tag_idle & !tag_switch;

    // Skid register: draining and refilling in one cycle keeps full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q_vld  <= 1'b0;
            req_q_addr <= '0;
            req_q_tag  <= '0;
        end else if (req_fire) begin
            req_q_vld  <= 1'b1;
            req_q_addr <= line_align(txreq_addr);
            req_q_tag  <= txreq_entry_id;
        end else if (fab_req_rdy) begin
            req_q_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= '0;
            protocol_err <= 1'b0;
        end else begin
            inflight_q   <= inflight_next_clear | inflight_set;
            protocol_err <= rsp_fire & (tag_idle | tag_switch | last_bad);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_cnt <= '0;
        end else begin
            case ({req_fire, line_done})
                2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
                2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    icache_refill_assembler u_assembler (
        .clk            (clk),
        .rst_n          (rst_n),
        .beat_we        (beat_we),
        .beat_tag       (rsp_beat.tag),
        .beat_data      (rsp_beat.data),
        .beat_err       (rsp_beat.err),
        .beat_cnt       (beat_cnt),
        .line_tag       (line_tag),
        .line_done      (line_done),
        .beat_rdy       (fab_rsp_rdy),
        .rxdat_vld      (rxdat_vld),
        .rxdat_rdy      (rxdat_rdy),
        .rxdat_data     (rxdat_data),
        .rxdat_entry_id (rxdat_entry_id),
        .rxdat_err      (rxdat_err)
    );

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed scoreboard bench for icache_refill_bridge; the expected rxdat_err
// follows whether ICACHE_REFILL_ERR_EN is defined for the build.
`timescale 1ns/1ps
module tb_icache_refill_bridge;
    import icache_refill_bridge_pkg::*;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [ENTRY_ID_WIDTH-1:0] tag;
    } req_exp_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0]     data;
        logic [ENTRY_ID_WIDTH-1:0] id;
        logic                      err;
    } line_exp_t;

`ifdef ICACHE_REFILL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic                      txreq_vld;
    logic                      txreq_rdy;
    logic [ADDR_WIDTH-1:0]     txreq_addr;
    logic [ENTRY_ID_WIDTH-1:0] txreq_entry_id;
    logic                      fab_req_vld;
    logic                      fab_req_rdy;
    logic [ADDR_WIDTH-1:0]     fab_req_addr;
    logic [ENTRY_ID_WIDTH-1:0] fab_req_tag;
    logic                      fab_rsp_vld;
    logic                      fab_rsp_rdy;
    logic [ENTRY_ID_WIDTH-1:0] fab_rsp_tag;
    logic [BEAT_WIDTH-1:0]     fab_rsp_data;
    logic                      fab_rsp_last;
    logic                      fab_rsp_err;
    logic                      rxdat_vld;
    logic                      rxdat_rdy;
    logic [LINE_WIDTH-1:0]     rxdat_data;
    logic [ENTRY_ID_WIDTH-1:0] rxdat_entry_id;
    logic                      rxdat_err;
    logic [ENTRY_ID_WIDTH:0]   outstanding_cnt;
    logic                      protocol_err;

    int        vectors;
    int        miscompares;
    int        cyc;
    int        perr_seen;
    int        exp_perr;
    int        acc[8];
    int        acc9;
    int        last0;
    int        tmp;
    req_exp_t  req_q[$];
    line_exp_t line_q[$];
    req_exp_t  req_e;
    line_exp_t line_e;

    icache_refill_bridge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .txreq_vld       (txreq_vld),
        .txreq_rdy       (txreq_rdy),
        .txreq_addr      (txreq_addr),
        .txreq_entry_id  (txreq_entry_id),
        .fab_req_vld     (fab_req_vld),
        .fab_req_rdy     (fab_req_rdy),
        .fab_req_addr    (fab_req_addr),
        .fab_req_tag     (fab_req_tag),
        .fab_rsp_vld     (fab_rsp_vld),
        .fab_rsp_rdy     (fab_rsp_rdy),
        .fab_rsp_tag     (fab_rsp_tag),
        .fab_rsp_data    (fab_rsp_data),
        .fab_rsp_last    (fab_rsp_last),
        .fab_rsp_err     (fab_rsp_err),
        .rxdat_vld       (rxdat_vld),
        .rxdat_rdy       (rxdat_rdy),
        .rxdat_data      (rxdat_data),
        .rxdat_entry_id  (rxdat_entry_id),
        .rxdat_err       (rxdat_err),
        .outstanding_cnt (outstanding_cnt),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_line(input string name, input logic [LINE_WIDTH-1:0] actual, input logic [LINE_WIDTH-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got no handshake, expected one within budget", name);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT completes an output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fab_req_vld && fab_req_rdy) begin
                if (req_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected fab_req: got addr %0h tag %0d, expected none", fab_req_addr, fab_req_tag);
                end else begin
                    req_e = req_q.pop_front();
                    check_output("fab_req_addr", 64'(fab_req_addr), 64'(req_e.addr));
                    check_output("fab_req_tag", 64'(fab_req_tag), 64'(req_e.tag));
                end
            end
            if (rxdat_vld && rxdat_rdy) begin
                if (line_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected rxdat: got id %0d, expected none", rxdat_entry_id);
                end else begin
                    line_e = line_q.pop_front();
                    check_line("rxdat_data", rxdat_data, line_e.data);
                    check_output("rxdat_entry_id", 64'(rxdat_entry_id), 64'(line_e.id));
                    check_output("rxdat_err", 64'(rxdat_err), 64'(line_e.err));
                end
            end
            if (protocol_err) begin
                perr_seen++;
            end
        end
    end

    function automatic logic [BEAT_WIDTH-1:0] beat_of(input logic [31:0] s);
        return {s ^ 32'h5A5A_5A5A, s + 32'h1111_1111, ~s, s};
    endfunction

    // Beat 0 occupies the low bits of the line: {D,C,B,A}.
    function automatic logic [LINE_WIDTH-1:0] make_line(input logic [31:0] seed);
        return {beat_of(seed + 32'd3), beat_of(seed + 32'd2), beat_of(seed + 32'd1), beat_of(seed)};
    endfunction

    task automatic apply_req(input logic [ADDR_WIDTH-1:0] addr, input logic [ENTRY_ID_WIDTH-1:0] id,
                             input logic [ADDR_WIDTH-1:0] exp_addr, output int acc_cyc);
        bit ok;
        int n;
        req_q.push_back('{addr: exp_addr, tag: id});
        txreq_vld      = 1'b1;
        txreq_addr     = addr;
        txreq_entry_id = id;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = txreq_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        txreq_vld = 1'b0;
        acc_cyc   = cyc;
        if (!ok) flag_fail("txreq accept");
    endtask

    task automatic apply_beat(input logic [ENTRY_ID_WIDTH-1:0] tag, input logic [BEAT_WIDTH-1:0] data,
                              input logic last, input logic err, output int acc_cyc);
        bit ok;
        int n;
        fab_rsp_vld  = 1'b1;
        fab_rsp_tag  = tag;
        fab_rsp_data = data;
        fab_rsp_last = last;
        fab_rsp_err  = err;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = fab_rsp_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        fab_rsp_vld = 1'b0;
        acc_cyc     = cyc;
        if (!ok) flag_fail("fab_rsp accept");
    endtask

    task automatic apply_line(input logic [ENTRY_ID_WIDTH-1:0] id, input logic [31:0] seed,
                              input int bad_last, input int err_beat, output int last_cyc);
        logic last;
        line_q.push_back('{data: make_line(seed), id: id, err: ERR_EN & (err_beat >= 0)});
        if (bad_last >= 0) exp_perr++;
        for (int k = 0; k < ICACHE_REFILL_BEATS; k++) begin
            last = (k == ICACHE_REFILL_BEATS - 1) ^ (k == bad_last);
            apply_beat(id, beat_of(seed + 32'(k)), last, k == err_beat, last_cyc);
            check_output("protocol_err per beat", 64'(protocol_err), 64'(k == bad_last));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; perr_seen = 0; exp_perr = 0;
        rst_n = 1'b0;
        txreq_vld = 1'b0; txreq_addr = '0; txreq_entry_id = '0;
        fab_req_rdy = 1'b1;
        fab_rsp_vld = 1'b0; fab_rsp_tag = '0; fab_rsp_data = '0; fab_rsp_last = 1'b0; fab_rsp_err = 1'b0;
        rxdat_rdy = 1'b1;

        // Reset state
        #12;
        check_output("reset fab_req_vld", 64'(fab_req_vld), 64'd0);
        check_output("reset rxdat_vld", 64'(rxdat_vld), 64'd0);
        check_output("reset outstanding_cnt", 64'(outstanding_cnt), 64'd0);
        check_output("reset protocol_err", 64'(protocol_err), 64'd0);
        check_output("reset rxdat_err", 64'(rxdat_err), 64'd0);
        check_output("reset txreq_rdy", 64'(txreq_rdy), 64'd1);
        check_output("reset fab_rsp_rdy", 64'(fab_rsp_rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single refill
        apply_req(32'h0000_1234, 3'd3, 32'h0000_1200, tmp);
        check_output("fab_req latency", 64'(fab_req_vld), 64'd1);
        check_output("outstanding after req", 64'(outstanding_cnt), 64'd1);
        apply_line(3'd3, 32'hA0A0_0000, -1, -1, tmp);
        check_output("rxdat_vld after last", 64'(rxdat_vld), 64'd1);
        check_output("outstanding after line", 64'(outstanding_cnt), 64'd0);
        idle(2);

        // Fill all ids back-to-back, then reuse id 0 the cycle it frees
        for (int i = 0; i < ENTRY_NUM; i++) begin
            apply_req(32'h0001_0005 + 32'(i * 64), ENTRY_ID_WIDTH'(i), 32'h0001_0000 + 32'(i * 64), acc[i]);
        end
        check_output("back-to-back accept cycles", 64'(acc[7] - acc[0]), 64'd7);
        check_output("outstanding full", 64'(outstanding_cnt), 64'd8);
        txreq_entry_id = 3'd0;
        #1;
        check_output("txreq_rdy dup id", 64'(txreq_rdy), 64'd0);
        fork
            apply_req(32'h0002_0040, 3'd0, 32'h0002_0040, acc9);
            apply_line(3'd0, 32'h1000_0000, -1, -1, last0);
        join
        check_output("reaccept same cycle", 64'(acc9 - last0), 64'd0);
        check_output("outstanding after swap", 64'(outstanding_cnt), 64'd8);
        for (int i = 1; i < ENTRY_NUM; i++) begin
            apply_line(ENTRY_ID_WIDTH'(i), 32'h1000_0000 + 32'(i * 16), -1, -1, tmp);
        end
        apply_line(3'd0, 32'h2000_0000, -1, -1, tmp);
        check_output("outstanding drained", 64'(outstanding_cnt), 64'd0);
        idle(2);

        // Fabric request stall keeps the skid register stable, then out-of-order completion
        fab_req_rdy = 1'b0;
        apply_req(32'h0000_2ABC, 3'd1, 32'h0000_2A80, tmp);
        txreq_entry_id = 3'd2;
        @(negedge clk);
        check_output("txreq_rdy skid full", 64'(txreq_rdy), 64'd0);
        check_output("fab_req_addr stable", 64'(fab_req_addr), 64'h2A80);
        check_output("fab_req_vld stable", 64'(fab_req_vld), 64'd1);
        idle(1);
        fab_req_rdy = 1'b1;
        apply_req(32'h0000_3000, 3'd2, 32'h0000_3000, tmp);
        apply_line(3'd2, 32'h3000_0000, -1, -1, tmp);
        apply_line(3'd1, 32'h3100_0000, -1, -1, tmp);
        check_output("outstanding after ooo", 64'(outstanding_cnt), 64'd0);
        idle(2);

        // rxdat backpressure holds the next beat
        rxdat_rdy = 1'b0;
        apply_req(32'h0000_4011, 3'd4, 32'h0000_4000, tmp);
        apply_line(3'd4, 32'h4000_0000, -1, -1, tmp);
        apply_req(32'h0000_5000, 3'd5, 32'h0000_5000, tmp);
        fork
            apply_line(3'd5, 32'h5000_0000, -1, -1, tmp);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_output("fab_rsp_rdy held", 64'(fab_rsp_rdy), 64'd0);
                    check_output("rxdat_vld held", 64'(rxdat_vld), 64'd1);
                    check_output("rxdat_entry_id held", 64'(rxdat_entry_id), 64'd4);
                end
                @(posedge clk);
                #1;
                rxdat_rdy = 1'b1;
            end
        join
        idle(2);

        // Beat for an idle tag is dropped
        apply_beat(3'd5, 128'hDEAD_BEEF, 1'b0, 1'b0, tmp);
        exp_perr++;
        check_output("perr idle tag", 64'(protocol_err), 64'd1);
        check_output("no rxdat for idle tag", 64'(rxdat_vld), 64'd0);
        idle(1);
        check_output("perr one cycle", 64'(protocol_err), 64'd0);

        // Early last flag on beat 1: line still completes after beat 3
        apply_req(32'h0000_6000, 3'd6, 32'h0000_6000, tmp);
        apply_line(3'd6, 32'h6000_0000, 1, -1, tmp);
        idle(2);

        // Tag change mid-line drops the intruding beat
        apply_req(32'h0000_7000, 3'd7, 32'h0000_7000, tmp);
        apply_req(32'h0000_7040, 3'd6, 32'h0000_7040, tmp);
        line_q.push_back('{data: make_line(32'h7000_0000), id: 3'd7, err: 1'b0});
        apply_beat(3'd7, beat_of(32'h7000_0000), 1'b0, 1'b0, tmp);
        apply_beat(3'd6, 128'hBAD0_BAD0, 1'b0, 1'b0, tmp);
        exp_perr++;
        check_output("perr tag switch", 64'(protocol_err), 64'd1);
        for (int k = 1; k < ICACHE_REFILL_BEATS; k++) begin
            apply_beat(3'd7, beat_of(32'h7000_0000 + 32'(k)), k == ICACHE_REFILL_BEATS - 1, 1'b0, tmp);
        end
        apply_line(3'd6, 32'h7100_0000, -1, -1, tmp);
        idle(2);

        // Beat error on beat 2, then a clean line
        apply_req(32'h0000_8000, 3'd2, 32'h0000_8000, tmp);
        apply_line(3'd2, 32'h8000_0000, -1, 2, tmp);
        apply_req(32'h0000_8040, 3'd3, 32'h0000_8040, tmp);
        apply_line(3'd3, 32'h8100_0000, -1, -1, tmp);
        idle(4);

        check_output("final outstanding", 64'(outstanding_cnt), 64'd0);
        check_output("pending rxdat expectations", 64'(line_q.size()), 64'd0);
        check_output("pending fab_req expectations", 64'(req_q.size()), 64'd0);
        check_output("protocol_err pulse count", 64'(perr_seen), 64'(exp_perr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
